// File: rtl/ps2_rx_fifo_if.sv
// rtl/ps2_rx_fifo_if.sv - received-byte valid/ready stream between the PS/2 receiver and its consumer
interface ps2_rx_fifo_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_byte,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_byte,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - filtered PS/2 frame receiver with parity/framing/timeout checks, byte FIFO and history
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 20,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FIFO_DEPTH     = 4,
  parameter int HIST_BYTES     = 4
) (
  input  logic                    clk100MHz,
  input  logic                    rst,
  input  logic                    PS2_Clk,
  input  logic                    PS2_Data,
  ps2_rx_fifo_if.master           rx,
  output logic [8*HIST_BYTES-1:0] history,
  output logic                    RX_Done,
  output logic                    parity_err,
  output logic                    frame_err,
  output logic                    overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int HW = 8 * HIST_BYTES;

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]            r_clk_sync;
  logic [1:0]            r_dat_sync;
  logic [FILTER_LEN-1:0] r_clk_sh;
  logic [FILTER_LEN-1:0] r_dat_sh;
  logic                  r_clk_f;
  logic                  r_dat_f;
  logic                  r_clk_f_q;

  logic [1:0]    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;

  logic          r_done;
  logic          r_perr;
  logic          r_ferr;
  logic          r_ovf;
  logic [HW-1:0] r_history;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_rx_byte;
  logic          r_rx_valid;

  logic          w_fall;
  logic          w_timeout;
  logic          w_stop_fall;
  logic          w_par_ok;
  logic          w_good;
  logic          w_par_bad;
  logic          w_frame_bad;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic [PW-1:0] w_rptr_nxt;
  logic [CW-1:0] w_cnt_after_pop;
  logic [CW-1:0] w_cnt_nxt;
  logic [HW-1:0] w_hist_nxt;

  // Filtered levels only move on a unanimous shift register, so short glitches never reach the FSM.
  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_sh   <= '1;
      r_dat_sh   <= '1;
      r_clk_f    <= 1'b1;
      r_dat_f    <= 1'b1;
      r_clk_f_q  <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], PS2_Clk};
      r_dat_sync <= {r_dat_sync[0], PS2_Data};
      r_clk_sh   <= {r_clk_sh[FILTER_LEN-2:0], r_clk_sync[1]};
      r_dat_sh   <= {r_dat_sh[FILTER_LEN-2:0], r_dat_sync[1]};
      if (&r_clk_sh) begin
        r_clk_f <= 1'b1;
      end else if (~|r_clk_sh) begin
        r_clk_f <= 1'b0;
      end
      if (&r_dat_sh) begin
        r_dat_f <= 1'b1;
      end else if (~|r_dat_sh) begin
        r_dat_f <= 1'b0;
      end
      r_clk_f_q  <= r_clk_f;
    end
  end

  assign w_fall      = r_clk_f_q & ~r_clk_f;
  assign w_timeout   = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TO_LAST);
  assign w_stop_fall = (r_state == S_STOP) && w_fall;
  assign w_par_ok    = ^{r_shift, r_par};
  assign w_frame_bad = w_stop_fall && !r_dat_f;
  assign w_par_bad   = w_stop_fall && r_dat_f && !w_par_ok;
  assign w_good      = w_stop_fall && r_dat_f && w_par_ok;

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      if (w_fall || (r_state == S_IDLE)) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          // A fall with data high is a bus glitch, not a start bit.
          if (w_fall && !r_dat_f) begin
            r_state   <= S_DATA;
            r_bit_cnt <= 3'd0;
          end
        end
        S_DATA: begin
          if (w_fall) begin
            r_shift   <= {r_dat_f, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end
          end else if (w_timeout) begin
            r_state <= S_IDLE;
          end
        end
        S_PARITY: begin
          if (w_fall) begin
            r_par   <= r_dat_f;
            r_state <= S_STOP;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
          end
        end
        S_STOP: begin
          if (w_fall || w_timeout) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  generate
    if (HIST_BYTES == 1) begin : g_hist_one
      assign w_hist_nxt = r_shift;
    end else begin : g_hist_many
      assign w_hist_nxt = {r_history[HW-9:0], r_shift};
    end
  endgenerate

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      r_done    <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovf     <= 1'b0;
      r_history <= '0;
    end else begin
      r_done <= w_good;
      r_perr <= w_par_bad;
      r_ferr <= w_frame_bad | w_timeout;
      r_ovf  <= w_good & w_full & ~w_pop;
      if (w_good) begin
        r_history <= w_hist_nxt;
      end
    end
  end

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_pop           = r_rx_valid & rx.rx_ready;
  assign w_full          = (r_count == FULL_CNT);
  assign w_push          = w_good & (~w_full | w_pop);
  assign w_rptr_nxt      = r_rptr + PW'(w_pop);
  assign w_cnt_after_pop = r_count - CW'(w_pop);
  assign w_cnt_nxt       = w_cnt_after_pop + CW'(w_push);

  always_ff @(posedge clk100MHz) begin
    if (w_push) begin
      r_mem[r_wptr] <= r_shift;
    end
  end

  // The head byte is registered; bypass the memory when the pushed byte becomes the head.
  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rx_byte  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      r_wptr     <= r_wptr + PW'(w_push);
      r_rptr     <= w_rptr_nxt;
      r_count    <= w_cnt_nxt;
      r_rx_valid <= (w_cnt_nxt != '0);
      if (w_push && (w_cnt_after_pop == '0)) begin
        r_rx_byte <= r_shift;
      end else if (w_cnt_after_pop != '0) begin
        r_rx_byte <= r_mem[w_rptr_nxt];
      end
    end
  end

  assign rx.rx_byte  = r_rx_byte;
  assign rx.rx_valid = r_rx_valid;
  assign history     = r_history;
  assign RX_Done     = r_done;
  assign parity_err  = r_perr;
  assign frame_err   = r_ferr;
  assign overflow    = r_ovf;

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised, fully synchronous PS/2 keyboard receiver: the successor to the single-byte PS/2 receiver. It synchronises and filters PS2_Clk and PS2_Data in the clk100MHz domain and receives 11-bit frames (start, 8 data LSB-first, odd parity, stop). It checks parity and framing, and aborts stalled frames on a timeout. Good bytes go into a valid/ready FIFO and a scan-code history register for the keyboard/paddle control logic.

## Interface
- FILTER_LEN, 20: filter shift depth in clk100MHz cycles; ≥2.
- TIMEOUT_CYCLES, 200000: maximum cycles between falling PS/2 clock edges inside a frame; ≥4.
- FIFO_DEPTH, 4: byte FIFO entries; power of 2, ≥2.
- HIST_BYTES, 4: bytes held in history; ≥1.
- clk100MHz  in  1  system clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- PS2_Clk  in  1  asynchronous PS/2 clock pin.
- PS2_Data  in  1  asynchronous PS/2 data pin.
- rx_byte  out  8  FIFO head byte; meaningful only while rx_valid=1.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts rx_byte.
- history  out  8*HIST_BYTES  last HIST_BYTES good bytes; newest in [7:0].
- RX_Done  out  1  one-cycle pulse per good frame.
- parity_err  out  1  one-cycle pulse: framing good, parity wrong.
- frame_err  out  1  one-cycle pulse: bad start/stop bit or timeout.
- overflow  out  1  one-cycle pulse: good byte dropped because the FIFO was full.

## Operation
- Input conditioning: each pin passes through a 2-flop synchroniser, then a FILTER_LEN shift register.
  - Filtered value goes to 1 or 0 only when the shift register is all-1 or all-0; otherwise it holds.
  - fall = filtered clock was 1 last cycle and is 0 this cycle. It is a one-cycle pulse.
  - Data is sampled as the filtered data value in the fall cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0, go to DATA with bit_cnt=0. On fall with data=1, stay in IDLE; no error (bus glitch).
  - DATA: on fall, shift the data bit in LSB-first. After bit_cnt=7, go to PARITY. bit_cnt is $clog2(8)=3 bits.
  - PARITY: on fall, store the parity bit and go to STOP.
  - STOP: on fall, evaluate the frame and go to IDLE.
    - Stop bit = 0: frame_err.
    - Stop bit = 1 and XOR(data, parity) = 0: parity_err.
    - Otherwise: good frame.
  - Only one error flag pulses per frame; frame_err has priority.
- Timeout: a cycle counter of $clog2(TIMEOUT_CYCLES) bits clears on every fall and in IDLE, and increments otherwise.
  - In DATA, PARITY or STOP, when the count reaches TIMEOUT_CYCLES-1: pulse frame_err, discard the partial frame, go to IDLE.
  - If fall and timeout occur in the same cycle, fall wins.
- Good frame actions:
  - Pulse RX_Done.
  - history <= {history[8*HIST_BYTES-9:0], byte}. For HIST_BYTES=1, history <= byte.
  - Push the byte to the FIFO.
- FIFO behaviour:
  - Pop when rx_valid & rx_ready.
  - Push when full and no pop in that cycle: byte dropped, overflow pulses; history is still updated.
  - Push and pop in the same cycle are both performed, including when full. The occupancy count is FIFO_DEPTH+1 values wide.
  - rx_byte is stable while rx_valid=1 and rx_ready=0.
- Errored frames touch neither the FIFO nor history.

## Timing
- Reset (synchronous, at the clk100MHz edge with rst=1):
  - Synchroniser and filter registers load all-1, and filtered values load 1, so there is no spurious fall after reset.
  - FSM goes to IDLE; counters and FIFO pointers clear.
  - rx_byte=0, rx_valid=0, history=0, RX_Done=0, parity_err=0, frame_err=0, overflow=0.
- Reset mid-frame: the partial frame is discarded silently and no flag pulses.
- Pin-to-fall latency: FILTER_LEN+3 cycles after a stable PS2_Clk transition. Pulses shorter than FILTER_LEN cycles are ignored.
- RX_Done, parity_err, frame_err, overflow and the history update are registered. They are visible the cycle after the stop-bit fall cycle, or the cycle after the timeout cycle.
- FIFO push and pop are registered. On a push into an empty FIFO, rx_valid rises together with RX_Done. On a pop, rx_byte and rx_valid update the cycle after the handshake.
- All outputs are driven from registers.

## Test plan
Bench parameters: defaults except TIMEOUT_CYCLES=20000. PS/2 half-period is 5000 cycles, with data changed mid-high.
- Frame 0x1C, parity 0, stop 1 -> one RX_Done pulse; rx_valid=1, rx_byte=0x1C, history=0x0000001C; no error flags.
- Frames 0x1C, 0xF0, 0x1C, with rx_ready=1 throughout -> three RX_Done pulses; history=0x001CF01C; FIFO empty at the end.
- Frame 0x1C with parity 1 -> parity_err pulses once; rx_valid stays 0; history unchanged. Same byte with stop 0 -> frame_err only.
- Start plus 4 data bits, then clock held high for 25000 cycles -> frame_err pulses once, 20000 cycles after the last fall. A following good 0x29 frame gives rx_byte=0x29.
- rx_ready=0; send 0x01 to 0x05 -> overflow pulses on 0x05 only. history[7:0]=0x05. Raising rx_ready drains 0x01 to 0x04 in order, then rx_valid=0.
- Low glitches of 10 cycles on PS2_Clk, plus rst asserted after 3 bits of a frame -> no flags, no FIFO writes; the next good 0x1C is received normally.
